// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, size constants, round-key slicing and
// the byte-level transforms used by the round unit and key expansion.
package aes_pkg;

   localparam int AES_BLOCK_W = 128;

   localparam int NR_128 = 10;
   localparam int NR_192 = 12;
   localparam int NR_256 = 14;
   localparam int NK_128 = 4;
   localparam int NK_192 = 6;
   localparam int NK_256 = 8;

   typedef enum logic [1:0] {IDLE, RUN, DONE} aes_state_t;

   // rk[0] sits in the most-significant slice of the expanded key; rk[nr] in [127:0]
   function automatic int rk_lo(input int r, input int nr);
      return AES_BLOCK_W * (nr - r);
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box as GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = b;
      inv = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input int j);
      logic [7:0] r;
      r = 8'h01;
      for (int k = 1; k < j; k++) r = xtime(r);
      return r;
   endfunction

   function automatic logic [AES_BLOCK_W-1:0] sub_bytes(input logic [AES_BLOCK_W-1:0] s);
      logic [AES_BLOCK_W-1:0] o;
      o = '0;
      for (int b = 0; b < 16; b++) o[127-8*b -: 8] = sbox(s[127-8*b -: 8]);
      return o;
   endfunction

   // Byte b holds row b%4, column b/4; row r rotates left by r columns
   function automatic logic [AES_BLOCK_W-1:0] shift_rows(input logic [AES_BLOCK_W-1:0] s);
      logic [AES_BLOCK_W-1:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [AES_BLOCK_W-1:0] mix_columns(input logic [AES_BLOCK_W-1:0] s);
      logic [AES_BLOCK_W-1:0] o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_key_expansion.sv
// Combinational AES key schedule; emits all Nr+1 round keys, rk[0] in the MSBs.
module aes_key_expansion
   import aes_pkg::*;
#(
   parameter int N  = 128,
   parameter int Nr = NR_128,
   parameter int Nk = NK_128
) (
   input  logic [N-1:0]                  key,
   output logic [AES_BLOCK_W*(Nr+1)-1:0] round_keys
);

   localparam int NW  = 4 * (Nr + 1);
   localparam int RKW = AES_BLOCK_W * (Nr + 1);

   logic [31:0] w [NW];
   logic [31:0] tmp;

   // NOTE: every combinational output is given a default before any branch so
   // that no path leaves it unassigned, which would infer a latch.
   always_comb begin
      tmp        = '0;
      round_keys = '0;
      for (int i = 0; i < Nk; i++) w[i] = key[N-1-32*i -: 32];
      for (int i = Nk; i < NW; i++) begin
         tmp = w[i-1];
         if (i % Nk == 0)
            tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon(i / Nk), 24'h0};
         else if (Nk > 6 && i % Nk == 4)
            tmp = sub_word(tmp);
         w[i] = w[i-Nk] ^ tmp;
      end
      for (int i = 0; i < NW; i++) round_keys[RKW-1-32*i -: 32] = w[i];
   end

endmodule

// File: rtl/aes_round_unit.sv
// Combinational single AES round; is_final bypasses MixColumns for the last round.
module aes_round_unit
   import aes_pkg::*;
(
   input  logic [AES_BLOCK_W-1:0] state,
   input  logic [AES_BLOCK_W-1:0] round_key,
   input  logic                   is_final,
   output logic [AES_BLOCK_W-1:0] result
);

   logic [AES_BLOCK_W-1:0] shifted;
   logic [AES_BLOCK_W-1:0] mixed;

   assign shifted = shift_rows(sub_bytes(state));
   assign mixed   = mix_columns(shifted);
   assign result  = (is_final ? shifted : mixed) ^ round_key;

endmodule

// File: rtl/aes_iter_encrypt_ctrl.sv
// Iterative AES encryptor: one shared round per clock, Nr+2 cycles per block.
// Optional abort input enabled by defining AES_ITER_ABORT_EN.
module aes_iter_encrypt_ctrl
   import aes_pkg::*;
#(
   parameter int N  = 128,
   parameter int Nr = NR_128,
   parameter int Nk = NK_128
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_BLOCK_W-1:0] in_data,
   input  logic [N-1:0]           key,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_BLOCK_W-1:0] out_data,
`ifdef AES_ITER_ABORT_EN
   input  logic                   abort,
`endif
   output logic                   busy
);

   localparam int CW  = $clog2(Nr + 1);
   localparam int RKW = AES_BLOCK_W * (Nr + 1);

   aes_state_t             state_q, state_d;
   logic [CW-1:0]          round_cnt;
   logic [AES_BLOCK_W-1:0] state_reg;
   logic [RKW-1:0]         rk_reg;
   logic [RKW-1:0]         exp_keys;
   logic [AES_BLOCK_W-1:0] round_key;
   logic [AES_BLOCK_W-1:0] round_out;
   logic                   is_final;
   logic                   accept;
   logic                   abort_hit;

   aes_key_expansion #(.N(N), .Nr(Nr), .Nk(Nk)) u_key_exp (
      .key        (key),
      .round_keys (exp_keys)
   );

   aes_round_unit u_round (
      .state     (state_reg),
      .round_key (round_key),
      .is_final  (is_final),
      .result    (round_out)
   );

   assign round_key = rk_reg[rk_lo(int'(round_cnt), Nr) +: AES_BLOCK_W];
   assign is_final  = (round_cnt == CW'(Nr));
   assign accept    = in_valid && in_ready;
   assign out_data  = (state_q == DONE) ? state_reg : '0;

`ifdef AES_ITER_ABORT_EN
   assign abort_hit = abort && (state_q != IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (is_final) state_d = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (abort_hit) state_d = IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: the round-key store is reset too, so a mid-run reset leaves no
   // trace of the previous key in the block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         round_cnt <= '0;
         state_reg <= '0;
         rk_reg    <= '0;
      end else if (abort_hit) begin
         round_cnt <= '0;
      end else if (accept) begin
         state_reg <= in_data ^ exp_keys[rk_lo(0, Nr) +: AES_BLOCK_W];
         rk_reg    <= exp_keys;
         round_cnt <= CW'(1);
      end else if (state_q == RUN) begin
         state_reg <= round_out;
         if (!is_final) round_cnt <= round_cnt + 1'b1;
      end else if (state_q == DONE && out_ready) begin
         round_cnt <= '0;
      end
   end

endmodule

// File: doc/aes_iter_encrypt_ctrl.md
# aes_iter_encrypt_ctrl

Iterative AES encryption sequencer. Accepts one plaintext block and cipher key per valid/ready transaction, expands and latches all round keys, then drives a single shared round datapath once per clock for Nr rounds. The ciphertext is presented on a valid/ready output. It is the area-reduced alternative to the fully unrolled encryptor: one round instance in place of Nr, traded for Nr+2 cycles per block.

## Interface
- N, 128: key width in bits (128/192/256).
- Nr, 10: round count (10/12/14, matching N).
- Nk, 4: key words (4/6/8, matching N).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request carries a valid block and key.
- in_ready  out  1  controller can accept a request.
- in_data  in  128  plaintext.
- key  in  N  cipher key, sampled with in_data.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  consumer accepts ciphertext.
- out_data  out  128  ciphertext.
- busy  out  1  high in RUN or DONE.

## Operation
- Three-state FSM:
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - state_reg <= in_data ^ rk[0].
    - Latch all 128*(Nr+1) round-key bits from KeyExpansion(key) into rk_reg.
    - round_cnt <= 1; go to RUN.
  - RUN, round_cnt in 1..Nr-1: state_reg <= full round (SubBytes, ShiftRows, MixColumns, AddRoundKey rk[round_cnt]); round_cnt++.
  - RUN, round_cnt==Nr: state_reg <= final round (no MixColumns) with rk[Nr]; go to DONE.
  - DONE: out_valid=1, out_data=state_reg. On out_ready go to IDLE.
- Round-key ordering: rk[0] is the most-significant 128-bit slice of the expansion output; rk[Nr] is bits [127:0].
- round_cnt width is clog2(Nr+1). Never exceeds Nr.
- in_ready is high only in IDLE. No acceptance in DONE, even when out_ready is high in the same cycle.
- in_data and key are don't-care outside the accept cycle. rk_reg and state_reg are held stable through RUN and DONE.
- out_data is held stable while out_valid&&!out_ready.
- Reset, asynchronous at any point including mid-RUN:
  - FSM to IDLE, round_cnt=0, state_reg=0, rk_reg=0.
  - In-flight block discarded; no out_valid is produced for it.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0.
- Accept edge = cycle 0. Rounds complete on edges 1..Nr. out_valid is high from cycle Nr onward.
- Latency from acceptance to out_valid: Nr cycles (10 for AES-128, 14 for AES-256).
- Minimum spacing between acceptances: Nr+2 cycles (out_ready tied high).
- out_ready held low stalls in DONE indefinitely, with no data loss.
- KeyExpansion is combinational on the key port and is captured only at the accept edge. This is the block's critical path.

## Configuration
- AES_ITER_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort high in RUN or DONE returns the FSM to IDLE on the next edge and clears round_cnt.
  - out_valid drops on that edge; no ciphertext is delivered.
  - abort in IDLE has no effect.
  - If abort and in_valid are both high in IDLE, the request is accepted.
- Not defined: no abort port; a block, once accepted, always completes.

## Structure
- Shared package aes_pkg holds:
  - FSM state enum (IDLE, RUN, DONE).
  - AES_BLOCK_W=128.
  - Round-count and Nk constants per key size.
  - round_key slice helper (index r to bit range).
- One sub-module, aes_round_unit: combinational single round with an is_final select that bypasses MixColumns, built from the existing SubBytes, ShiftRows and AddRoundKey blocks. The controller instantiates it once.
- KeyExpansion is instantiated directly in the controller.

## Test plan
- FIPS-197 App. B, AES-128:
  - key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32.
  - out_valid first high exactly 10 cycles after acceptance.
- FIPS-197 C.3, N=256/Nr=14/Nk=8:
  - key 000102..1f, pt 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089.
  - 14-cycle latency.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0 throughout; release -> in_ready high the following cycle.
- Back-to-back with out_ready=1: C.1 vector (key 000102..0f -> 69c4e0d86a7b0430d8cdb78070b4c55a) followed by the App. B vector -> both ciphertexts correct, acceptances exactly 12 cycles apart.
- Mid-run reset: assert rst_n=0 at round 5 -> all outputs at reset values immediately; a new request after release yields the correct ciphertext.
- With AES_ITER_ABORT_EN: abort at round 3 -> IDLE next cycle, no out_valid pulse; next vector encrypts correctly.
